// File: rtl/pmod_i2c_pkg.sv
// Shared definitions for the PMOD I2C block: i2c_master command encoding and arbiter states.
package pmod_i2c_pkg;

    localparam logic [1:0] I2CMASTER_START = 2'd0;
    localparam logic [1:0] I2CMASTER_STOP  = 2'd1;
    localparam logic [1:0] I2CMASTER_WRITE = 2'd2;
    localparam logic [1:0] I2CMASTER_READ  = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_AUTOSTOP,
        ARB_WAITSTOP
    } arb_state_t;

endpackage

// File: rtl/pmod_i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_pick
    import pmod_i2c_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // Scan last+1 .. last+NREQ so the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pmod_i2c_arbiter.sv
// Transaction-level round-robin arbiter in front of i2c_master, with auto-STOP on
// abandoned transactions and an idle watchdog.
module pmod_i2c_arbiter
    import pmod_i2c_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter logic [19:0] TIMEOUT = 20'd500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_grant,
    input  logic [2*NREQ-1:0] req_cmd,
    input  logic [8*NREQ-1:0] req_data_in,
    input  logic [NREQ-1:0]   req_ack_in,
    input  logic [NREQ-1:0]   req_stb,
    output logic [NREQ-1:0]   req_ready,
    output logic              timeout,
    output logic [1:0]        m_cmd,
    output logic [7:0]        m_data_in,
    output logic              m_ack_in,
    output logic              m_stb,
    input  logic              m_ready
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic            bus_open_q, bus_open_d;
    logic [19:0]     wd_cnt_q, wd_cnt_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic [1:0]      owner_cmd;
    logic            acc_stb;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req  (req_lock),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign req_grant = grant_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_d     = last_q;
        bus_open_d = bus_open_q;
        wd_cnt_d   = wd_cnt_q;
        req_ready  = '0;
        timeout    = 1'b0;
        m_cmd      = I2CMASTER_STOP;
        m_data_in  = '0;
        m_ack_in   = 1'b1;
        m_stb      = 1'b0;
        owner_cmd  = req_cmd[{owner_q, 1'b0} +: 2];
        acc_stb    = req_stb[owner_q] & m_ready;

        case (state_q)
            ARB_IDLE: begin
                if (m_ready && |req_lock) begin
                    state_d    = ARB_GRANT;
                    grant_d    = pick_gnt;
                    owner_d    = pick_idx;
                    last_d     = pick_idx;
                    wd_cnt_d   = '0;
                    bus_open_d = 1'b0;
                end
            end
            ARB_GRANT: begin
                req_ready = grant_q & {NREQ{m_ready}};
                m_cmd     = owner_cmd;
                m_data_in = req_data_in[{owner_q, 3'b000} +: 8];
                m_ack_in  = req_ack_in[owner_q];
                m_stb     = acc_stb;
                if (acc_stb) begin
                    wd_cnt_d = '0;
                    if (owner_cmd == I2CMASTER_START)
                        bus_open_d = 1'b1;
                    else if (owner_cmd == I2CMASTER_STOP)
                        bus_open_d = 1'b0;
                end else if (m_ready) begin
                    if (wd_cnt_q != '1)
                        wd_cnt_d = wd_cnt_q + 20'd1;
                    // A normal release takes precedence over the watchdog.
                    if (!req_lock[owner_q]) begin
                        grant_d = '0;
                        state_d = bus_open_q ? ARB_AUTOSTOP : ARB_IDLE;
                    end else if (TIMEOUT != 20'd0 && wd_cnt_q == TIMEOUT - 20'd1) begin
                        grant_d = '0;
                        timeout = 1'b1;
                        state_d = bus_open_q ? ARB_AUTOSTOP : ARB_IDLE;
                    end
                end
            end
            ARB_AUTOSTOP: begin
                m_cmd      = I2CMASTER_STOP;
                m_stb      = 1'b1;
                bus_open_d = 1'b0;
                state_d    = ARB_WAITSTOP;
            end
            ARB_WAITSTOP: begin
                if (m_ready)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_q     <= IW'(NREQ - 1);
            bus_open_q <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            bus_open_q <= bus_open_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_pmod_i2c_arbiter.sv
// Directed bench for pmod_i2c_arbiter (NREQ=2, TIMEOUT=16); m_ready is driven by the bench.
module tb_pmod_i2c_arbiter;
    import pmod_i2c_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_lock;
    logic [1:0]  req_grant;
    logic [3:0]  req_cmd;
    logic [15:0] req_data_in;
    logic [1:0]  req_ack_in;
    logic [1:0]  req_stb;
    logic [1:0]  req_ready;
    logic        timeout;
    logic [1:0]  m_cmd;
    logic [7:0]  m_data_in;
    logic        m_ack_in;
    logic        m_stb;
    logic        m_ready;

    int checks   = 0;
    int failures = 0;

    pmod_i2c_arbiter #(.NREQ(2), .TIMEOUT(20'd16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_lock    (req_lock),
        .req_grant   (req_grant),
        .req_cmd     (req_cmd),
        .req_data_in (req_data_in),
        .req_ack_in  (req_ack_in),
        .req_stb     (req_stb),
        .req_ready   (req_ready),
        .timeout     (timeout),
        .m_cmd       (m_cmd),
        .m_data_in   (m_data_in),
        .m_ack_in    (m_ack_in),
        .m_stb       (m_stb),
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_stb(input int r, input logic [1:0] c, input logic [7:0] d);
        req_stb            = '0;
        req_stb[r]         = 1'b1;
        req_cmd[2*r +: 2]  = c;
        req_data_in[8*r +: 8] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, req_grant, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_mstb"},  m_stb, 0);
        check({tag, "_mcmd"},  m_cmd, I2CMASTER_STOP);
        check({tag, "_mdata"}, m_data_in, 0);
        check({tag, "_mack"},  m_ack_in, 1);
        check({tag, "_to"},    timeout, 0);
    endtask

    initial begin
        rst         = 1'b0;
        req_lock    = '0;
        req_cmd     = '0;
        req_data_in = '0;
        req_ack_in  = 2'b11;
        req_stb     = '0;
        m_ready     = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Lock0 alone: full transaction, clean release.
        req_lock = 2'b01;
        #1 check("t1_grant_before_edge", req_grant, 2'b00);
        tick();
        check("t1_grant", req_grant, 2'b01);
        check("t1_ready", req_ready, 2'b01);
        drive_stb(0, I2CMASTER_START, 8'h00);
        req_ack_in = 2'b10;
        #1 check("t1_start_stb", m_stb, 1);
        check("t1_start_cmd", m_cmd, I2CMASTER_START);
        check("t1_ack_mux", m_ack_in, 0);
        tick();
        drive_stb(0, I2CMASTER_WRITE, 8'h30);
        #1 check("t1_w30_data", m_data_in, 8'h30);
        check("t1_w30_cmd", m_cmd, I2CMASTER_WRITE);
        tick();
        drive_stb(0, I2CMASTER_WRITE, 8'h00);
        tick();
        drive_stb(0, I2CMASTER_STOP, 8'h00);
        #1 check("t1_stop_cmd", m_cmd, I2CMASTER_STOP);
        check("t1_stop_stb", m_stb, 1);
        tick();
        req_stb    = '0;
        req_lock   = 2'b00;
        req_ack_in = 2'b11;
        #1 check("t1_rel_stb", m_stb, 0);
        tick();
        check("t1_idle_grant", req_grant, 2'b00);
        check("t1_idle_ready", req_ready, 2'b00);
        check("t1_idle_stb", m_stb, 0);
        tick();
        check("t1_no_extra_stb", m_stb, 0);

        // Simultaneous locks from reset (last=1): 0 first, then 1, then 0 again.
        rst = 1'b1;
        #1 check("t2_rst_grant", req_grant, 2'b00);
        tick();
        rst = 1'b0;
        req_lock = 2'b11;
        tick();
        check("t2_first_grant", req_grant, 2'b01);
        req_lock = 2'b10;
        tick();
        check("t2_gap_grant", req_grant, 2'b00);
        tick();
        check("t2_second_grant", req_grant, 2'b10);
        req_lock = 2'b11;
        req_cmd[3:2] = I2CMASTER_READ;
        req_cmd[1:0] = I2CMASTER_WRITE;
        req_stb = 2'b01;
        #1 check("t5_nonowner_stb", m_stb, 0);
        check("t5_owner_cmd", m_cmd, I2CMASTER_READ);
        check("t5_ready", req_ready, 2'b10);
        tick();
        check("t2_hold_grant", req_grant, 2'b10);
        req_stb  = '0;
        req_lock = 2'b01;
        tick();
        check("t2_rel1_grant", req_grant, 2'b00);
        tick();
        check("t2_third_grant", req_grant, 2'b01);

        // Owner 1 abandons an open transaction: one forced STOP.
        req_lock = 2'b10;
        tick();
        check("t3_idle_grant", req_grant, 2'b00);
        tick();
        check("t3_grant", req_grant, 2'b10);
        drive_stb(1, I2CMASTER_START, 8'h00);
        tick();
        drive_stb(1, I2CMASTER_WRITE, 8'hA4);
        #1 check("t3_wa4_data", m_data_in, 8'hA4);
        check("t3_wa4_stb", m_stb, 1);
        tick();
        req_stb  = '0;
        req_lock = 2'b00;
        #1 check("t3_rel_stb", m_stb, 0);
        tick();
        m_ready = 1'b0;
        #1 check("t3_autostop_stb", m_stb, 1);
        check("t3_autostop_cmd", m_cmd, I2CMASTER_STOP);
        check("t3_autostop_grant", req_grant, 2'b00);
        check("t3_autostop_ready", req_ready, 2'b00);
        check("t3_autostop_to", timeout, 0);
        tick();
        check("t3_wait_stb", m_stb, 0);
        tick();
        check("t3_wait2_stb", m_stb, 0);
        check("t3_wait2_grant", req_grant, 2'b00);
        m_ready  = 1'b1;
        req_lock = 2'b01;
        tick();
        check("t3_idle_after_wait", req_grant, 2'b00);
        tick();
        check("t3_regrant0", req_grant, 2'b01);

        // Watchdog: owner 0 opens the bus then idles with lock held.
        drive_stb(0, I2CMASTER_START, 8'h00);
        tick();
        req_stb  = '0;
        req_lock = 2'b11;
        #1;
        for (int i = 1; i <= 15; i++) begin
            check("t4_no_timeout", timeout, 0);
            tick();
        end
        check("t4_timeout_pulse", timeout, 1);
        check("t4_grant_at_to", req_grant, 2'b01);
        tick();
        check("t4_to_cleared", timeout, 0);
        check("t4_forced_stb", m_stb, 1);
        check("t4_forced_cmd", m_cmd, I2CMASTER_STOP);
        check("t4_forced_grant", req_grant, 2'b00);
        tick();
        check("t4_wait_stb", m_stb, 0);
        tick();
        check("t4_idle_grant", req_grant, 2'b00);
        tick();
        check("t4_other_grant", req_grant, 2'b10);
        req_lock = 2'b00;
        tick();

        // Async reset in the middle of a WRITE.
        req_lock = 2'b01;
        tick();
        check("t6_grant", req_grant, 2'b01);
        drive_stb(0, I2CMASTER_START, 8'h00);
        tick();
        drive_stb(0, I2CMASTER_WRITE, 8'h55);
        #1 check("t6_write_stb", m_stb, 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("t6_async");
        req_stb = '0;
        #1 rst = 1'b0;
        tick();
        check("t6_regrant", req_grant, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
